// File: rtl/laplace_line_feeder.sv
// Laplace line feeder: buffers two previous rows in ping-pong RAMs and emits rows n-2, n-1, n as aligned strobes.
// Optional: define LAPLACE_FEEDER_ZERO_PAD_EN to strobe/filter every row with zero-padded missing rows.
module laplace_line_feeder #(
    parameter int unsigned WORDS_PER_LINE = 64,
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned NUM_ROWS       = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_pix_data_valid,
    input  logic [63:0] i_pix_data,
    output logic        o_pix_data_ack,
    output logic        o_line1_data_valid,
    output logic [63:0] o_line1_data,
    output logic        o_line2_data_valid,
    output logic [63:0] o_line2_data,
    output logic        o_line3_data_valid,
    output logic [63:0] o_line3_data,
    output logic        o_filter,
    input  logic        i_row_done,
    output logic        o_frame_done
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ROW_W  = $clog2(NUM_ROWS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FILTER = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_WORD    = ADDR_W'(WORDS_PER_LINE - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW_CNT = ROW_W'(NUM_ROWS);

`ifdef LAPLACE_FEEDER_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    logic [1:0]        state, state_d;
    logic [ADDR_W-1:0] word_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic              sel;
    logic              ack_d, filter_d, frame_done_d;
    logic              accept_c, last_word_c, strobed_row_c;
    logic [DATA_W-1:0] ram0 [WORDS_PER_LINE];
    logic [DATA_W-1:0] ram1 [WORDS_PER_LINE];
    logic [DATA_W-1:0] rd_n2_c, rd_n1_c;

    assign accept_c      = i_pix_data_valid & o_pix_data_ack;
    assign last_word_c   = (word_cnt == LAST_WORD);
    // Rows 0 and 1 only prime the RAMs unless zero padding supplies the missing rows
    assign strobed_row_c = ZERO_PAD || (row_cnt >= ROW_W'(2));
    assign rd_n2_c       = sel ? ram1[word_cnt] : ram0[word_cnt];
    assign rd_n1_c       = sel ? ram0[word_cnt] : ram1[word_cnt];

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d      = state;
        ack_d        = 1'b0;
        filter_d     = 1'b0;
        frame_done_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_STREAM;
                    ack_d   = 1'b1;
                end
            end
            S_STREAM: begin
                ack_d = 1'b1;
                if (accept_c && last_word_c && strobed_row_c) begin
                    state_d = S_DRAIN;
                    ack_d   = 1'b0;
                end
            end
            S_DRAIN: begin
                // Last word's strobe is on the outputs this cycle
                state_d  = S_FILTER;
                filter_d = 1'b1;
            end
            S_FILTER: begin
                filter_d = 1'b1;
                if (i_row_done) begin
                    filter_d = 1'b0;
                    if (row_cnt == LAST_ROW_CNT) begin
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_STREAM;
                        ack_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_pix_data_ack <= 1'b0;
            o_filter       <= 1'b0;
            o_frame_done   <= 1'b0;
        end else begin
            o_pix_data_ack <= ack_d;
            o_filter       <= filter_d;
            o_frame_done   <= frame_done_d;
        end
    end

    // Word/row counters and ping-pong select
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            word_cnt <= '0;
            row_cnt  <= '0;
            sel      <= 1'b0;
        end else if (frame_done_d) begin
            word_cnt <= '0;
            row_cnt  <= '0;
            sel      <= 1'b0;
        end else if (accept_c) begin
            if (last_word_c) begin
                word_cnt <= '0;
                row_cnt  <= row_cnt + ROW_W'(1);
                sel      <= ~sel;
            end else begin
                word_cnt <= word_cnt + ADDR_W'(1);
            end
        end
    end

    // Line strobes and data, one cycle after accept
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_line1_data_valid <= 1'b0;
            o_line2_data_valid <= 1'b0;
            o_line3_data_valid <= 1'b0;
            o_line1_data       <= '0;
            o_line2_data       <= '0;
            o_line3_data       <= '0;
        end else begin
            o_line1_data_valid <= accept_c & strobed_row_c;
            o_line2_data_valid <= accept_c & strobed_row_c;
            o_line3_data_valid <= accept_c & strobed_row_c;
            if (accept_c) begin
                o_line1_data <= (ZERO_PAD && row_cnt < ROW_W'(2)) ? '0 : rd_n2_c;
                o_line2_data <= (ZERO_PAD && row_cnt == '0) ? '0 : rd_n1_c;
                o_line3_data <= i_pix_data;
            end
        end
    end

    // Ping-pong RAM write; the same-edge read above sees the old word
    always_ff @(posedge i_clk) begin
        if (accept_c) begin
            if (sel) ram1[word_cnt] <= i_pix_data;
            else     ram0[word_cnt] <= i_pix_data;
        end
    end

endmodule
